// File: rtl/player_mover.sv
// Player-motion engine: rate-limits start, resolves turn/move/strafe, and checks each axis against the map grid.
// Latency: 6 cycles from start to done with a zero-wait grid, +1 per grid wait cycle, 2 when rate-limited; the grid stalls via grid_valid.
module player_mover #(
  parameter int X_W         = 14,
  parameter int Y_W         = 13,
  parameter int ANGLE_W     = 8,
  parameter int DIR_W       = 15,
  parameter int CELL_SHIFT  = 8,
  parameter int MAP_W       = 40,
  parameter int MAP_H       = 30,
  parameter int TURN_SPEED  = 2,
  parameter int MOVE_PERIOD = 1000000
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  output logic               done,
  input  logic               turn_right,
  input  logic               turn_left,
  input  logic               move_forward,
  input  logic               move_backward,
  input  logic               strafe_right,
  input  logic               strafe_left,
  input  logic [X_W-1:0]     cur_pos_x,
  input  logic [Y_W-1:0]     cur_pos_y,
  input  logic [ANGLE_W-1:0] cur_angle,
  input  logic [DIR_W-1:0]   dir_x,
  input  logic [DIR_W-1:0]   dir_y,
  output logic [X_W-1:0]     next_pos_x,
  output logic [Y_W-1:0]     next_pos_y,
  output logic [ANGLE_W-1:0] next_angle,
  output logic               grid_req,
  output logic [5:0]         grid_x,
  output logic [4:0]         grid_y,
  input  logic               grid_valid,
  input  logic [2:0]         grid_out
);

  localparam int CNT_W  = $clog2(MOVE_PERIOD + 1);
  localparam int SUM_XW = (X_W > DIR_W + 1) ? X_W : DIR_W + 1;
  localparam int SUM_YW = (Y_W > DIR_W + 1) ? Y_W : DIR_W + 1;
  localparam logic [X_W-1:0]     MAP_W_LIM = X_W'(MAP_W);
  localparam logic [Y_W-1:0]     MAP_H_LIM = Y_W'(MAP_H);
  localparam logic [ANGLE_W-1:0] TURN_STEP = ANGLE_W'(TURN_SPEED);
  localparam logic [CNT_W-1:0]   RELOAD    = CNT_W'(MOVE_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_CALC   = 3'd2,
    S_LOOK_X = 3'd3,
    S_LOOK_Y = 3'd4,
    S_COMMIT = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [ANGLE_W-1:0] angle;
  } pose_t;

  state_t                 state, state_n;
  logic [CNT_W-1:0]       rate_cnt;
  pose_t                  next_pose;
  pose_t                  lat_pose;
  logic [X_W-1:0]         acc_x;
  logic [Y_W-1:0]         acc_y;
  logic signed [DIR_W:0]  dx_q, dy_q;

  // Signed key pairs: opposing keys cancel to zero.
  logic f_pos, f_neg, s_pos, s_neg, t_pos, t_neg;
  assign f_pos = move_forward  & ~move_backward;
  assign f_neg = move_backward & ~move_forward;
  assign s_pos = strafe_right  & ~strafe_left;
  assign s_neg = strafe_left   & ~strafe_right;
  assign t_pos = turn_right    & ~turn_left;
  assign t_neg = turn_left     & ~turn_right;

  function automatic logic signed [DIR_W:0] scale(input logic p, input logic n,
                                                   input logic signed [DIR_W:0] v);
    if (p)      return v;
    else if (n) return -v;
    else        return '0;
  endfunction

  logic signed [DIR_W:0] dir_x_s, dir_y_s, dx_c, dy_c;
  logic [ANGLE_W-1:0]    angle_c;
  assign dir_x_s = {dir_x[DIR_W-1], dir_x};
  assign dir_y_s = {dir_y[DIR_W-1], dir_y};
  assign dx_c = scale(f_pos, f_neg, dir_x_s) - scale(s_pos, s_neg, dir_y_s);
  assign dy_c = scale(f_pos, f_neg, dir_y_s) + scale(s_pos, s_neg, dir_x_s);
  assign angle_c = t_pos ? cur_angle + TURN_STEP :
                   t_neg ? cur_angle - TURN_STEP : cur_angle;

  logic [X_W-1:0] cx, look_x, cell_x;
  logic [Y_W-1:0] cy, look_y, cell_y;
  logic           move_nz, in_map, cell_free;

  assign cx = X_W'(SUM_XW'(lat_pose.x) + SUM_XW'(dx_q));
  assign cy = Y_W'(SUM_YW'(lat_pose.y) + SUM_YW'(dy_q));

  // The y lookup uses the already-resolved x, so a blocked x leaves y free to slide.
  assign look_x    = (state == S_LOOK_X) ? cx : acc_x;
  assign look_y    = (state == S_LOOK_X) ? lat_pose.y : cy;
  assign cell_x    = look_x >> CELL_SHIFT;
  assign cell_y    = look_y >> CELL_SHIFT;
  assign in_map    = (cell_x < MAP_W_LIM) && (cell_y < MAP_H_LIM);
  assign move_nz   = (state == S_LOOK_X) ? (dx_q != '0) : (dy_q != '0);
  assign grid_req  = ((state == S_LOOK_X) || (state == S_LOOK_Y)) && move_nz && in_map;
  assign grid_x    = 6'(cell_x);
  assign grid_y    = 5'(cell_y);
  assign cell_free = grid_valid && (grid_out == 3'd0);

  assign done       = (state == S_DONE);
  assign next_pos_x = next_pose.x;
  assign next_pos_y = next_pose.y;
  assign next_angle = next_pose.angle;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (start) state_n = S_CHECK;
      S_CHECK:  state_n = (rate_cnt == '0) ? S_CALC : S_DONE;
      S_CALC:   state_n = S_LOOK_X;
      S_LOOK_X: if (!grid_req || grid_valid) state_n = S_LOOK_Y;
      S_LOOK_Y: if (!grid_req || grid_valid) state_n = S_COMMIT;
      S_COMMIT: state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= S_IDLE;
      rate_cnt  <= '0;
      next_pose <= '{x: cur_pos_x, y: cur_pos_y, angle: cur_angle};
      lat_pose  <= '{x: cur_pos_x, y: cur_pos_y, angle: cur_angle};
      acc_x     <= cur_pos_x;
      acc_y     <= cur_pos_y;
      dx_q      <= '0;
      dy_q      <= '0;
    end else begin
      state <= state_n;
      if ((state == S_CHECK) && (rate_cnt == '0))
        rate_cnt <= RELOAD;
      else if (rate_cnt != '0)
        rate_cnt <= rate_cnt - CNT_W'(1);

      case (state)
        S_CALC: begin
          lat_pose <= '{x: cur_pos_x, y: cur_pos_y, angle: angle_c};
          dx_q     <= dx_c;
          dy_q     <= dy_c;
          acc_x    <= cur_pos_x;
          acc_y    <= cur_pos_y;
        end
        S_LOOK_X: if (grid_req && cell_free) acc_x <= cx;
        S_LOOK_Y: if (grid_req && cell_free) acc_y <= cy;
        S_COMMIT: next_pose <= '{x: acc_x, y: acc_y, angle: lat_pose.angle};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_player_mover.sv
// Directed bench for player_mover: a negedge grid responder with a programmable wait and wall map,
// and a linear sequence of update requests checked with immediate assertions.
module tb_player_mover;

  logic        clock = 1'b0;
  logic        resetn, start, done;
  logic        turn_right, turn_left, move_forward, move_backward, strafe_right, strafe_left;
  logic [13:0] cur_pos_x, next_pos_x;
  logic [12:0] cur_pos_y, next_pos_y;
  logic [7:0]  cur_angle, next_angle;
  logic [14:0] dir_x, dir_y;
  logic        grid_req, grid_valid;
  logic [5:0]  grid_x;
  logic [4:0]  grid_y;
  logic [2:0]  grid_out;

  int n_cmp = 0;
  int n_err = 0;
  int grid_wait = 0;
  int wait_cnt = 0;
  int wall_mode = 0;
  int req_cycles = 0;
  int stab_err = 0;
  int lat, n;
  logic manual_grid = 1'b0;
  logic [5:0] first_gx, last_gx;
  logic [4:0] first_gy, last_gy;

  always #5 clock = ~clock;

  player_mover #(.MOVE_PERIOD(16)) dut (
    .clock(clock), .resetn(resetn), .start(start), .done(done),
    .turn_right(turn_right), .turn_left(turn_left),
    .move_forward(move_forward), .move_backward(move_backward),
    .strafe_right(strafe_right), .strafe_left(strafe_left),
    .cur_pos_x(cur_pos_x), .cur_pos_y(cur_pos_y), .cur_angle(cur_angle),
    .dir_x(dir_x), .dir_y(dir_y),
    .next_pos_x(next_pos_x), .next_pos_y(next_pos_y), .next_angle(next_angle),
    .grid_req(grid_req), .grid_x(grid_x), .grid_y(grid_y),
    .grid_valid(grid_valid), .grid_out(grid_out)
  );

  function automatic logic is_wall(input logic [5:0] gx, input logic [4:0] gy);
    case (wall_mode)
      1:       return (gx == 6'd2 && gy == 5'd1);
      2:       return (gx == 6'd2 && gy == 5'd1) || (gx == 6'd1 && gy == 5'd2);
      default: return 1'b0;
    endcase
  endfunction

  // Grid model: answers each request after grid_wait cycles and tracks coordinate stability.
  always @(negedge clock) begin
    if (!manual_grid) begin
      if (grid_req) begin
        if (wait_cnt == 0) begin
          first_gx = grid_x;
          first_gy = grid_y;
        end else if (grid_x !== first_gx || grid_y !== first_gy) begin
          stab_err++;
        end
        req_cycles++;
        if (wait_cnt >= grid_wait) begin
          grid_valid = 1'b1;
          grid_out   = is_wall(grid_x, grid_y) ? 3'd1 : 3'd0;
          last_gx    = grid_x;
          last_gy    = grid_y;
          wait_cnt   = 0;
        end else begin
          grid_valid = 1'b0;
          grid_out   = 3'd0;
          wait_cnt++;
        end
      end else begin
        grid_valid = 1'b0;
        wait_cnt   = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Key order: turn_right, turn_left, move_forward, move_backward, strafe_right, strafe_left.
  task automatic set_keys(input logic [5:0] k);
    {turn_right, turn_left, move_forward, move_backward, strafe_right, strafe_left} = k;
  endtask

  task automatic run_update(output int latency);
    int cyc;
    @(negedge clock);
    start = 1'b1;
    req_cycles = 0;
    stab_err = 0;
    @(negedge clock);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 60) begin
      @(negedge clock);
      cyc++;
    end
    latency = done ? cyc : -1;
  endtask

  task automatic check_pose(input string tag, input logic [13:0] ex, input logic [12:0] ey,
                            input logic [7:0] ea);
    check({tag, "_x"}, 32'(next_pos_x), 32'(ex));
    check({tag, "_y"}, 32'(next_pos_y), 32'(ey));
    check({tag, "_angle"}, 32'(next_angle), 32'(ea));
  endtask

  task automatic cool_down();
    repeat (20) @(negedge clock);
  endtask

  initial begin
    resetn = 1'b0;
    start = 1'b0;
    set_keys(6'b000000);
    cur_pos_x = 14'h0180;
    cur_pos_y = 13'h0180;
    cur_angle = 8'h40;
    dir_x = 15'd16;
    dir_y = 15'd0;
    grid_valid = 1'b0;
    grid_out = 3'd0;

    // Reset loads the current pose and idles the handshake.
    repeat (3) @(negedge clock);
    check_pose("reset", 14'h0180, 13'h0180, 8'h40);
    check("reset_done", 32'(done), 32'd0);
    check("reset_grid_req", 32'(grid_req), 32'd0);
    resetn = 1'b1;

    // Plain forward step, x lookup only.
    set_keys(6'b001000);
    run_update(lat);
    check("fwd_latency", lat, 6);
    check("fwd_req_cycles", req_cycles, 1);
    check("fwd_cell", {26'd0, last_gx}, 32'd1);
    check("fwd_cell_y", {27'd0, last_gy}, 32'd1);
    check_pose("fwd", 14'h0190, 13'h0180, 8'h40);

    // Back-to-back start hits the rate limiter.
    run_update(lat);
    check("rate_latency", lat, 2);
    check("rate_req_cycles", req_cycles, 0);
    check_pose("rate", 14'h0190, 13'h0180, 8'h40);
    cool_down();

    // Diagonal into an x wall: slide along y.
    wall_mode = 1;
    cur_pos_x = 14'h01F8;
    cur_pos_y = 13'h01F8;
    dir_x = 15'd16;
    dir_y = 15'd16;
    run_update(lat);
    check("slide_latency", lat, 6);
    check("slide_req_cycles", req_cycles, 2);
    check("slide_y_cell_x", {26'd0, last_gx}, 32'd1);
    check("slide_y_cell_y", {27'd0, last_gy}, 32'd2);
    check_pose("slide", 14'h01F8, 13'h0208, 8'h40);
    cool_down();

    // Both axes blocked, turn still applies.
    wall_mode = 2;
    set_keys(6'b101000);
    run_update(lat);
    check("corner_latency", lat, 6);
    check_pose("corner", 14'h01F8, 13'h01F8, 8'h42);
    cool_down();

    // Left turn across angle zero with a wall ahead.
    wall_mode = 1;
    cur_angle = 8'h01;
    dir_y = 15'd0;
    set_keys(6'b011000);
    run_update(lat);
    check("wrap_req_cycles", req_cycles, 1);
    check_pose("wrap", 14'h01F8, 13'h01F8, 8'hFF);
    cool_down();

    // All opposing pairs cancel: no lookups, pose copied from current.
    cur_pos_x = 14'h0300;
    cur_pos_y = 13'h0280;
    dir_y = 15'd16;
    set_keys(6'b110011);
    run_update(lat);
    check("cancel_latency", lat, 6);
    check("cancel_req_cycles", req_cycles, 0);
    check_pose("cancel", 14'h0300, 13'h0280, 8'h01);
    cool_down();

    // Backward off the left map edge is blocked without a request; strafe right still moves y.
    wall_mode = 0;
    cur_pos_x = 14'h0008;
    cur_pos_y = 13'h0180;
    cur_angle = 8'h40;
    dir_x = 15'd16;
    dir_y = 15'd0;
    set_keys(6'b000110);
    run_update(lat);
    check("edge_latency", lat, 6);
    check("edge_req_cycles", req_cycles, 1);
    check("edge_cell_x", {26'd0, last_gx}, 32'd0);
    check("edge_cell_y", {27'd0, last_gy}, 32'd1);
    check_pose("edge", 14'h0008, 13'h0190, 8'h40);
    cool_down();

    // Three grid wait cycles on the x lookup.
    cur_pos_x = 14'h0180;
    grid_wait = 3;
    set_keys(6'b001000);
    run_update(lat);
    check("wait_latency", lat, 9);
    check("wait_req_cycles", req_cycles, 4);
    check("wait_stable", stab_err, 0);
    check("wait_cell_x", {26'd0, last_gx}, 32'd1);
    check_pose("wait", 14'h0190, 13'h0180, 8'h40);
    cool_down();

    // Reset in the middle of an unanswered lookup.
    grid_wait = 50;
    cur_pos_x = 14'h0280;
    cur_angle = 8'h10;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!grid_req && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("abort_req_seen", 32'(grid_req), 32'd1);
    repeat (2) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    manual_grid = 1'b1;
    check("abort_grid_req", 32'(grid_req), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check_pose("abort", 14'h0280, 13'h0180, 8'h10);
    resetn = 1'b1;
    grid_valid = 1'b1;
    grid_out = 3'd0;
    repeat (4) @(negedge clock);
    check("late_valid_grid_req", 32'(grid_req), 32'd0);
    check("late_valid_done", 32'(done), 32'd0);
    check_pose("late_valid", 14'h0280, 13'h0180, 8'h10);
    grid_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/player_mover.md
# player_mover

Parametrised player-motion engine that sits between the keyboard decoder and the renderer's player registers. On each `start` it applies a rate limit, then resolves turning, forward/backward motion and strafing. It checks each axis of the move separately against the map grid over a request/valid handshake, so the player slides along walls instead of stopping dead. It pulses `done` when the new pose is valid.

## Interface
Parameters:
- `X_W`, 14: x position width (unsigned fixed-point, cell size 2^`CELL_SHIFT`).
- `Y_W`, 13: y position width.
- `ANGLE_W`, 8: angle width (full turn = 2^`ANGLE_W`).
- `DIR_W`, 15: width of signed direction vector inputs.
- `CELL_SHIFT`, 8: position-to-grid right shift.
- `MAP_W`, 40: map width in cells.
- `MAP_H`, 30: map height in cells.
- `TURN_SPEED`, 2: angle units per update.
- `MOVE_PERIOD`, 1000000: minimum cycles between accepted updates.

Ports:
- `clock` in 1: single clock, all logic on posedge.
- `resetn` in 1: reset, synchronous, active-low.
- `start` in 1: request one update; sampled in IDLE only.
- `done` out 1: one-cycle pulse, update finished.
- `turn_right`, `turn_left`, `move_forward`, `move_backward`, `strafe_right`, `strafe_left` in 1 each: movement keys.
- `cur_pos_x` in `X_W`; `cur_pos_y` in `Y_W`; `cur_angle` in `ANGLE_W`: current pose; held stable from `start` to `done`.
- `dir_x`, `dir_y` in `DIR_W`: signed unit direction for `cur_angle`.
- `next_pos_x` out `X_W`; `next_pos_y` out `Y_W`; `next_angle` out `ANGLE_W`: registered resolved pose.
- `grid_req` out 1: grid lookup request.
- `grid_x` out 6; `grid_y` out 5: requested cell, stable while `grid_req` is high.
- `grid_valid` in 1: `grid_out` is valid.
- `grid_out` in 3: cell type, 0 = empty.

## Operation
- States: IDLE, CHECK, CALC, LOOK_X, LOOK_Y, COMMIT, DONE.
- Rate counter: width fits `MOVE_PERIOD`. Decrements every cycle and saturates at 0.
- IDLE -> CHECK on `start`.
- CHECK:
  - Counter == 0: go to CALC and reload the counter with `MOVE_PERIOD`-1.
  - Otherwise: go to DONE with the outputs left unchanged.
- CALC: latches the inputs.
  - f = `move_forward` − `move_backward`; s = `strafe_right` − `strafe_left`; t = `turn_right` − `turn_left`. Each is in {−1, 0, +1}, so opposing keys cancel.
  - dx = f·`dir_x` − s·`dir_y`; dy = f·`dir_y` + s·`dir_x`. Computed signed at `DIR_W`+1 bits, sign-extended, added modulo 2^width.
  - Candidate angle = `cur_angle` + t·`TURN_SPEED` mod 2^`ANGLE_W`.
  - Movement uses the pre-turn direction.
  - Goes to LOOK_X.
- LOOK_X:
  - dx == 0: skip to LOOK_Y.
  - Otherwise the cell is (cx>>`CELL_SHIFT`, `cur_pos_y`>>`CELL_SHIFT`), with cx = `cur_pos_x`+dx.
  - Cell index ≥ `MAP_W` or ≥ `MAP_H`: blocked with no request.
  - Otherwise assert `grid_req`. On the cycle `grid_valid`=1, accept cx if `grid_out`==0, else keep `cur_pos_x`. Then go to LOOK_Y.
- LOOK_Y: same as LOOK_X, using accepted x and cy = `cur_pos_y`+dy. Then go to COMMIT.
- COMMIT: writes `next_*` from the accepted values. The angle is always applied; collision never blocks turning. Goes to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Reset (`resetn`=0 at posedge):
  - State = IDLE, counter = 0, `done`=0, `grid_req`=0.
  - `next_pos_x/y`, `next_angle` load `cur_*`.
  - Reset mid-lookup abandons the request; a late `grid_valid` is ignored.

## Timing
- `grid_req` rises on entry to LOOK_X/LOOK_Y and stays high, with `grid_x`/`grid_y` stable, through the cycle `grid_valid` is sampled. It drops the next cycle.
- `grid_valid` may be high in the first request cycle (zero wait). `grid_valid` outside a request is ignored.
- Latency from the `start` sample edge to `done` high (zero-wait grid):
  - Both axes looked up: 6 cycles.
  - Each skipped axis or out-of-map axis: −0, since the state still passes. Each wait cycle: +1.
  - Rate-limited: 2 cycles (CHECK, DONE).
- `next_*` change only at the COMMIT edge and are valid while `done` is high.
- `start` outside IDLE is ignored.

## Test plan
- Reset with `resetn`=0, `cur_pos`=(0x0180,0x0180), `cur_angle`=0x40 -> `next_*` = (0x0180,0x0180,0x40), `done`=0, `grid_req`=0.
- Counter 0, forward, `dir`=(+16,0), grid always 0, zero-wait -> one request at cell (1,1), x=0x0190, y unchanged, `done` 6 cycles after `start`. Immediate second `start` -> `done` after 2 cycles, pose unchanged.
- Forward, `dir`=(+16,+16), x cell wall, y cell empty -> x held, y+16 (slide). Both walls -> pose unchanged except angle.
- `turn_left`+`move_forward` with a wall ahead, `cur_angle`=0x01 -> `next_angle`=0xFF (wrap), position unchanged.
- `turn_left`+`turn_right` and `strafe_left`+`strafe_right` together -> no change, no `grid_req`.
- `grid_valid` delayed 3 cycles -> `grid_x`/`grid_y` stable throughout, `done` at 9 cycles. `resetn` low during the wait -> IDLE, `grid_req`=0 next cycle, later `grid_valid` ignored.
